pcpi_dispatch: RTL and testbench

PCPI_DISPATCH -- requirements
Module: pcpi_dispatch

---
 rtl/pcpi_dispatch.sv | 157 +++++++++++++++
 tb/tb_pcpi_dispatch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_dispatch.sv
// PCPI dispatcher: decodes RV32M instructions from the CPU and routes each one to
// the multiplier or divider coprocessor, with timeout and abort handling.
module pcpi_dispatch #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit ENABLE_DIV     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_pcpi_valid,
  input  logic [31:0] cpu_pcpi_insn,
  input  logic [31:0] cpu_pcpi_rs1,
  input  logic [31:0] cpu_pcpi_rs2,
  output logic        cpu_pcpi_wr,
  output logic [31:0] cpu_pcpi_rd,
  output logic        cpu_pcpi_wait,
  output logic        cpu_pcpi_ready,
  output logic [31:0] co_pcpi_insn,
  output logic [31:0] co_pcpi_rs1,
  output logic [31:0] co_pcpi_rs2,
  output logic        mul_pcpi_valid,
  input  logic        mul_pcpi_wr,
  input  logic [31:0] mul_pcpi_rd,
  input  logic        mul_pcpi_ready,
  output logic        div_pcpi_valid,
  input  logic        div_pcpi_wr,
  input  logic [31:0] div_pcpi_rd,
  input  logic        div_pcpi_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2, DRAIN = 2'd3} state_t;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          sel_div_r, sel_div_nxt_s;
  logic [31:0]   insn_r, insn_nxt_s, rs1_r, rs1_nxt_s, rs2_r, rs2_nxt_s;
  logic          mul_valid_r, mul_valid_nxt_s, div_valid_r, div_valid_nxt_s;
  logic          wait_r, wait_nxt_s, ready_r, ready_nxt_s, wr_r, wr_nxt_s;
  logic [31:0]   rd_r, rd_nxt_s;
  logic          is_mext_s, claim_s, sel_ready_s, sel_wr_s;
  logic [31:0]   sel_rd_s;

  assign is_mext_s   = (cpu_pcpi_insn[6:0] == 7'b0110011) && (cpu_pcpi_insn[31:25] == 7'b0000001);
  assign claim_s     = cpu_pcpi_valid && is_mext_s && (!cpu_pcpi_insn[14] || ENABLE_DIV);
  // Only the coprocessor latched at claim time is listened to.
  assign sel_ready_s = sel_div_r ? div_pcpi_ready : mul_pcpi_ready;
  assign sel_wr_s    = sel_div_r ? div_pcpi_wr    : mul_pcpi_wr;
  assign sel_rd_s    = sel_div_r ? div_pcpi_rd    : mul_pcpi_rd;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    sel_div_nxt_s   = sel_div_r;
    insn_nxt_s      = insn_r;
    rs1_nxt_s       = rs1_r;
    rs2_nxt_s       = rs2_r;
    mul_valid_nxt_s = 1'b0;
    div_valid_nxt_s = 1'b0;
    wait_nxt_s      = 1'b0;
    ready_nxt_s     = 1'b0;
    wr_nxt_s        = 1'b0;
    rd_nxt_s        = rd_r;
    case (state_r)
      IDLE: begin
        if (claim_s) begin
          state_nxt_s     = BUSY;
          cnt_nxt_s       = '0;
          sel_div_nxt_s   = cpu_pcpi_insn[14];
          insn_nxt_s      = cpu_pcpi_insn;
          rs1_nxt_s       = cpu_pcpi_rs1;
          rs2_nxt_s       = cpu_pcpi_rs2;
          mul_valid_nxt_s = !cpu_pcpi_insn[14];
          div_valid_nxt_s = cpu_pcpi_insn[14];
          wait_nxt_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        // Abort outranks a coincident ready; ready outranks the timeout.
        if (!cpu_pcpi_valid) begin
          state_nxt_s = IDLE;
        end else if (sel_ready_s) begin
          state_nxt_s = RESP;
          ready_nxt_s = 1'b1;
          wr_nxt_s    = sel_wr_s;
          rd_nxt_s    = sel_rd_s;
        end else if (cnt_r == TO_LAST) begin
          state_nxt_s = DRAIN;
        end else begin
          cnt_nxt_s       = cnt_r + CW'(1);
          mul_valid_nxt_s = !sel_div_r;
          div_valid_nxt_s = sel_div_r;
          wait_nxt_s      = 1'b1;
        end
      end
      RESP: begin
        state_nxt_s = DRAIN;
      end
      DRAIN: begin
        if (!cpu_pcpi_valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      sel_div_r   <= 1'b0;
      insn_r      <= 32'd0;
      rs1_r       <= 32'd0;
      rs2_r       <= 32'd0;
      mul_valid_r <= 1'b0;
      div_valid_r <= 1'b0;
      wait_r      <= 1'b0;
      ready_r     <= 1'b0;
      wr_r        <= 1'b0;
      rd_r        <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      sel_div_r   <= sel_div_nxt_s;
      insn_r      <= insn_nxt_s;
      rs1_r       <= rs1_nxt_s;
      rs2_r       <= rs2_nxt_s;
      mul_valid_r <= mul_valid_nxt_s;
      div_valid_r <= div_valid_nxt_s;
      wait_r      <= wait_nxt_s;
      ready_r     <= ready_nxt_s;
      wr_r        <= wr_nxt_s;
      rd_r        <= rd_nxt_s;
    end
  end

  assign cpu_pcpi_wr    = wr_r;
  assign cpu_pcpi_rd    = rd_r;
  assign cpu_pcpi_wait  = wait_r;
  assign cpu_pcpi_ready = ready_r;
  assign co_pcpi_insn   = insn_r;
  assign co_pcpi_rs1    = rs1_r;
  assign co_pcpi_rs2    = rs2_r;
  assign mul_pcpi_valid = mul_valid_r;
  assign div_pcpi_valid = div_valid_r;

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Directed bench for pcpi_dispatch: table of transactions against stub coprocessors,
// plus hand-written timeout, reset, abort and unclaimed sequences.
module tb_pcpi_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_valid;
  logic [31:0] cpu_insn, cpu_rs1, cpu_rs2;
  logic        cpu_wr, cpu_wait, cpu_ready;
  logic [31:0] cpu_rd, co_insn, co_rs1, co_rs2;
  logic        mul_valid, mul_wr, mul_ready;
  logic [31:0] mul_rd;
  logic        div_valid, div_wr, div_ready;
  logic [31:0] div_rd;
  logic        nd_wr, nd_wait, nd_ready, nd_mul_valid, nd_div_valid;
  logic [31:0] nd_rd, nd_insn, nd_rs1, nd_rs2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pcpi_dispatch #(.TIMEOUT_CYCLES(16), .ENABLE_DIV(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_pcpi_valid(cpu_valid), .cpu_pcpi_insn(cpu_insn), .cpu_pcpi_rs1(cpu_rs1), .cpu_pcpi_rs2(cpu_rs2),
    .cpu_pcpi_wr(cpu_wr), .cpu_pcpi_rd(cpu_rd), .cpu_pcpi_wait(cpu_wait), .cpu_pcpi_ready(cpu_ready),
    .co_pcpi_insn(co_insn), .co_pcpi_rs1(co_rs1), .co_pcpi_rs2(co_rs2),
    .mul_pcpi_valid(mul_valid), .mul_pcpi_wr(mul_wr), .mul_pcpi_rd(mul_rd), .mul_pcpi_ready(mul_ready),
    .div_pcpi_valid(div_valid), .div_pcpi_wr(div_wr), .div_pcpi_rd(div_rd), .div_pcpi_ready(div_ready)
  );

  pcpi_dispatch #(.TIMEOUT_CYCLES(16), .ENABLE_DIV(1'b0)) u_nodiv (
    .clk(clk), .reset(reset),
    .cpu_pcpi_valid(cpu_valid), .cpu_pcpi_insn(cpu_insn), .cpu_pcpi_rs1(cpu_rs1), .cpu_pcpi_rs2(cpu_rs2),
    .cpu_pcpi_wr(nd_wr), .cpu_pcpi_rd(nd_rd), .cpu_pcpi_wait(nd_wait), .cpu_pcpi_ready(nd_ready),
    .co_pcpi_insn(nd_insn), .co_pcpi_rs1(nd_rs1), .co_pcpi_rs2(nd_rs2),
    .mul_pcpi_valid(nd_mul_valid), .mul_pcpi_wr(mul_wr), .mul_pcpi_rd(mul_rd), .mul_pcpi_ready(mul_ready),
    .div_pcpi_valid(nd_div_valid), .div_pcpi_wr(div_wr), .div_pcpi_rd(div_rd), .div_pcpi_ready(div_ready)
  );

  typedef struct {
    string       name;
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          lat;
    logic [31:0] stub_rd;
    logic        stub_wr;
    logic        claim;
    logic        is_div;
    logic [31:0] exp_rd;
    logic        exp_wr;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_insn = v.insn; cpu_rs1 = v.rs1; cpu_rs2 = v.rs2;
    if (!v.claim) begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        chk({v.name, " unclaimed ctl"}, {28'd0, mul_valid, div_valid, cpu_wait, cpu_ready}, 32'd0);
      end
      cpu_valid = 1'b0;
      @(negedge clk);
      return;
    end
    for (int c = 1; c <= v.lat; c++) begin
      @(negedge clk);
      chk({v.name, " busy ctl"}, {28'd0, mul_valid, div_valid, cpu_wait, cpu_ready},
          {28'd0, !v.is_div, v.is_div, 1'b1, 1'b0});
      if (c == 1) begin
        chk({v.name, " co_insn"}, co_insn, v.insn);
        chk({v.name, " co_rs1"}, co_rs1, v.rs1);
        chk({v.name, " co_rs2"}, co_rs2, v.rs2);
        if (v.is_div) chk({v.name, " nodiv ignores"}, {30'd0, nd_div_valid, nd_wait}, 32'd0);
        // The unselected coprocessor shouts a bogus result the whole time.
        if (v.is_div) begin mul_ready = 1'b1; mul_wr = 1'b1; mul_rd = 32'hDEAD_BEEF; end
        else          begin div_ready = 1'b1; div_wr = 1'b1; div_rd = 32'hDEAD_BEEF; end
      end
      if (c == v.lat) begin
        if (v.is_div) begin div_ready = 1'b1; div_wr = v.stub_wr; div_rd = v.stub_rd; end
        else          begin mul_ready = 1'b1; mul_wr = v.stub_wr; mul_rd = v.stub_rd; end
      end
    end
    @(negedge clk);
    chk({v.name, " resp ctl"}, {27'd0, cpu_ready, cpu_wr, cpu_wait, mul_valid, div_valid},
        {27'd0, 1'b1, v.exp_wr, 3'b000});
    chk({v.name, " resp rd"}, cpu_rd, v.exp_rd);
    mul_ready = 1'b0; mul_wr = 1'b0; mul_rd = 32'd0;
    div_ready = 1'b0; div_wr = 1'b0; div_rd = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk({v.name, " drain ctl"}, {27'd0, cpu_ready, cpu_wr, cpu_wait, mul_valid, div_valid}, 32'd0);
    end
    chk({v.name, " rd hold"}, cpu_rd, v.exp_rd);
    cpu_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int seen;
    vec_t v;
    vecs[0] = '{"mul",    mk(7'b0000001, 3'b000, 7'b0110011), 32'd3, 32'd7, 1, 32'd21, 1'b1, 1'b1, 1'b0, 32'd21, 1'b1};
    vecs[1] = '{"divu",   mk(7'b0000001, 3'b101, 7'b0110011), 32'd20, 32'd3, 5, 32'd6, 1'b1, 1'b1, 1'b1, 32'd6, 1'b1};
    vecs[2] = '{"mulhu",  mk(7'b0000001, 3'b011, 7'b0110011), 32'h8000_0000, 32'd4, 3, 32'd2, 1'b1, 1'b1, 1'b0, 32'd2, 1'b1};
    vecs[3] = '{"rem",    mk(7'b0000001, 3'b110, 7'b0110011), 32'd20, 32'd3, 2, 32'd2, 1'b0, 1'b1, 1'b1, 32'd2, 1'b0};
    vecs[4] = '{"add",    mk(7'b0000000, 3'b000, 7'b0110011), 32'd3, 32'd7, 0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    vecs[5] = '{"badop",  mk(7'b0000001, 3'b000, 7'b0110111), 32'd3, 32'd7, 0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};

    reset = 1'b1; cpu_valid = 1'b0; cpu_insn = 32'd0; cpu_rs1 = 32'd0; cpu_rs2 = 32'd0;
    mul_ready = 1'b0; mul_wr = 1'b0; mul_rd = 32'd0;
    div_ready = 1'b0; div_wr = 1'b0; div_rd = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset ctl", {27'd0, cpu_ready, cpu_wr, cpu_wait, mul_valid, div_valid}, 32'd0);
    chk("reset rd", cpu_rd, 32'd0);
    chk("reset co_insn", co_insn, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Timeout: multiplier never answers.
    @(negedge clk);
    cpu_valid = 1'b1; cpu_insn = vecs[0].insn; cpu_rs1 = 32'd9; cpu_rs2 = 32'd9;
    hi = 0; seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mul_valid) hi++;
      if (cpu_ready || div_valid) seen++;
    end
    chk("timeout valid cycles", hi, 32'd16);
    chk("timeout no ready", seen, 32'd0);
    chk("timeout drain ctl", {30'd0, cpu_wait, mul_valid}, 32'd0);
    cpu_valid = 1'b0;
    @(negedge clk);
    run_txn(vecs[0]);

    // Reset in the third BUSY cycle.
    @(negedge clk);
    cpu_valid = 1'b1; cpu_insn = vecs[0].insn; cpu_rs1 = 32'd5; cpu_rs2 = 32'd6;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("pre-reset busy", {30'd0, mul_valid, cpu_wait}, 32'd3);
    end
    reset = 1'b1; cpu_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset ctl", {27'd0, cpu_ready, cpu_wr, cpu_wait, mul_valid, div_valid}, 32'd0);
    chk("midreset rd", cpu_rd, 32'd0);
    chk("midreset co_insn", co_insn, 32'd0);
    chk("midreset co_rs1", co_rs1, 32'd0);
    chk("midreset co_rs2", co_rs2, 32'd0);
    v = vecs[0];
    v.name = "mul1000"; v.rs1 = 32'd1000; v.rs2 = 32'd1000; v.lat = 4;
    v.stub_rd = 32'd1000000; v.exp_rd = 32'd1000000;
    run_txn(v);

    // Abort coincident with multiplier ready.
    @(negedge clk);
    cpu_valid = 1'b1; cpu_insn = vecs[0].insn; cpu_rs1 = 32'd11; cpu_rs2 = 32'd9;
    @(negedge clk);
    @(negedge clk);
    cpu_valid = 1'b0; mul_ready = 1'b1; mul_wr = 1'b1; mul_rd = 32'd99;
    @(negedge clk);
    chk("abort ctl", {28'd0, cpu_ready, cpu_wait, mul_valid, div_valid}, 32'd0);
    mul_ready = 1'b0; mul_wr = 1'b0; mul_rd = 32'd0;
    cpu_valid = 1'b1;
    @(negedge clk);
    chk("abort back to idle", {30'd0, mul_valid, cpu_wait}, 32'd3);
    mul_ready = 1'b1; mul_wr = 1'b1; mul_rd = 32'd99;
    @(negedge clk);
    chk("post-abort ready", {31'd0, cpu_ready}, 32'd1);
    chk("post-abort rd", cpu_rd, 32'd99);
    mul_ready = 1'b0; mul_wr = 1'b0;
    cpu_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
